data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/dmem_pkg.sv | 40 ++++
 rtl/tx_fifo.sv | 59 +++++
 rtl/data_mem_responder.sv | 102 ++++++++++
 tb/tb_data_mem_responder.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory responder: MMIO window, register
// offsets and STATUS bit layout.
package dmem_pkg;

  // MMIO window is the 16-byte block at 0x4000_0000.
  localparam logic [27:0] MmioBaseHi = 28'h4000000;

  // Word offsets inside the MMIO window (memaddr[3:2]).
  typedef enum logic [1:0] {
    RegTxData = 2'd0,
    RegStatus = 2'd1,
    RegCycle  = 2'd2,
    RegRsvd   = 2'd3
  } mmio_reg_e;

  // STATUS register bit positions.
  localparam int unsigned StatusEmptyBit = 0;
  localparam int unsigned StatusFullBit  = 1;
  localparam int unsigned StatusOvfBit   = 2;
  localparam int unsigned StatusCountLsb = 4;
  localparam int unsigned StatusCountW   = 4;

  function automatic logic is_mmio(input logic [31:0] addr);
    return addr[31:4] == MmioBaseHi;
  endfunction

  function automatic logic [31:0] pack_status(input logic                    empty,
                                              input logic                    full,
                                              input logic                    ovf,
                                              input logic [StatusCountW-1:0] count);
    logic [31:0] s;
    s                                = '0;
    s[StatusEmptyBit]                = empty;
    s[StatusFullBit]                 = full;
    s[StatusOvfBit]                  = ovf;
    s[StatusCountLsb +: StatusCountW] = count;
    return s;
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// Console TX byte FIFO. Simultaneous push and pop are always accepted, even
// when full; a push into a full FIFO without a pop is dropped and latches a
// sticky overflow flag until clear_overflow.
module tx_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [7:0]                 push_data,
  input  logic                       pop_ready,
  input  logic                       clear_overflow,
  output logic [7:0]                 head,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [7:0]      mem_q [DEPTH];
  logic [PtrW-1:0] rptr_q, wptr_q;
  logic [CntW-1:0] count_q;
  logic            ovf_q;
  logic            pop, accept;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CntW'(DEPTH));
  assign pop      = pop_ready && !empty;
  assign accept   = push && (!full || pop);
  assign count    = count_q;
  assign overflow = ovf_q;
  assign head     = empty ? 8'h00 : mem_q[rptr_q];

  // Pointers, occupancy and sticky overflow; pointers wrap naturally (power-of-2 depth).
  always_ff @(posedge clk) begin
    if (rst) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (accept) wptr_q <= wptr_q + PtrW'(1);
      if (pop)    rptr_q <= rptr_q + PtrW'(1);
      if (accept && !pop)      count_q <= count_q + CntW'(1);
      else if (!accept && pop) count_q <= count_q - CntW'(1);
      if (clear_overflow)              ovf_q <= 1'b0;
      else if (push && full && !pop)   ovf_q <= 1'b1;
    end
  end

  // Storage array; contents are don't-care once popped or after reset.
  always_ff @(posedge clk) begin
    if (!rst && accept) mem_q[wptr_q] <= push_data;
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data memory responder: byte-writable RAM with zero-latency reads plus a
// small MMIO block (console TX FIFO, STATUS, optional cycle counter).
// Optional feature: define DMEM_CYCLE_COUNTER_EN to build the CYCLE counter.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned WORDS      = 1024,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] memaddr,
  input  logic [31:0] memin,
  input  logic        memwrite,
  input  logic [3:0]  iobytes,
  output logic [31:0] memout,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int unsigned AW   = $clog2(WORDS);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]     ram [WORDS];
  logic [AW-1:0]   ram_idx;
  logic            mmio;
  mmio_reg_e       reg_sel;
  logic            fifo_push, fifo_clr_ovf;
  logic            fifo_empty, fifo_full, fifo_ovf;
  logic [CntW-1:0] fifo_count;
  logic [31:0]     status_val;
  logic [31:0]     cycle_val;
  logic            unused_addr;

  assign mmio        = is_mmio(memaddr);
  assign reg_sel     = mmio_reg_e'(memaddr[3:2]);
  assign ram_idx     = memaddr[AW+1:2];
  assign unused_addr = ^{memaddr[1:0], memaddr[31:AW+2]};

  // Writes during reset are ignored everywhere, including the FIFO push.
  assign fifo_push    = !rst && memwrite && mmio && (reg_sel == RegTxData) && iobytes[0];
  assign fifo_clr_ovf = !rst && memwrite && mmio && (reg_sel == RegStatus);

  // Byte-lane RAM write; RAM is deliberately never reset.
  always_ff @(posedge clk) begin
    if (!rst && memwrite && !mmio) begin
      for (int i = 0; i < 4; i++) begin
        if (iobytes[i]) ram[ram_idx][8*i +: 8] <= memin[8*i +: 8];
      end
    end
  end

  tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk            (clk),
    .rst            (rst),
    .push           (fifo_push),
    .push_data      (memin[7:0]),
    .pop_ready      (tx_ready),
    .clear_overflow (fifo_clr_ovf),
    .head           (tx_data),
    .empty          (fifo_empty),
    .full           (fifo_full),
    .count          (fifo_count),
    .overflow       (fifo_ovf)
  );

  assign tx_valid   = !fifo_empty;
  assign status_val = pack_status(fifo_empty, fifo_full, fifo_ovf,
                                  StatusCountW'(fifo_count));

`ifdef DMEM_CYCLE_COUNTER_EN
  logic [31:0] cycle_q;

  // Free-running cycle counter, cleared by reset, wraps at 2^32.
  always_ff @(posedge clk) begin
    if (rst) cycle_q <= '0;
    else     cycle_q <= cycle_q + 32'd1;
  end

  assign cycle_val = cycle_q;
`else
  assign cycle_val = '0;
`endif

  // Zero-latency read mux: RAM word or MMIO register.
  always_comb begin
    memout = ram[ram_idx];
    if (mmio) begin
      unique case (reg_sel)
        RegTxData: memout = '0;
        RegStatus: memout = status_val;
        RegCycle:  memout = cycle_val;
        RegRsvd:   memout = '0;
        default:   memout = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios with literal
// expectations plus a randomized phase, all checked every cycle against a
// queue/array based reference model.
module tb_data_mem_responder;

  localparam int unsigned W     = 64;
  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] memaddr, memin, memout;
  logic        memwrite, tx_valid, tx_ready;
  logic [3:0]  iobytes;
  logic [7:0]  tx_data;

  data_mem_responder #(
    .WORDS      (W),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .memaddr  (memaddr),
    .memin    (memin),
    .memwrite (memwrite),
    .iobytes  (iobytes),
    .memout   (memout),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit started = 0;

  // Reference model state.
  logic [31:0] m_ram [W];
  logic [3:0]  m_known [W];
  logic [7:0]  q[$];
  bit          m_ovf;
  logic [31:0] m_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit addr_is_mmio(input logic [31:0] a);
    return (a >= 32'h4000_0000) && (a <= 32'h4000_000F);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a >> 2) % W);
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] k);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = k[i] ? 8'hFF : 8'h00;
    return m;
  endfunction

  function automatic logic [31:0] model_status();
    int sz;
    logic [31:0] s;
    sz = q.size();
    s  = (sz % 16) * 16;
    if (sz == 0)     s += 1;
    if (sz == DEPTH) s += 2;
    if (m_ovf)       s += 4;
    return s;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (addr_is_mmio(a)) begin
      case ((a - 32'h4000_0000) / 4)
        1: return model_status();
`ifdef DMEM_CYCLE_COUNTER_EN
        2: return m_cyc;
`endif
        default: return 32'h0;
      endcase
    end
    return m_ram[word_of(a)];
  endfunction

  function automatic logic [31:0] model_mask(input logic [31:0] a);
    if (addr_is_mmio(a)) return 32'hFFFF_FFFF;
    return lane_mask(m_known[word_of(a)]);
  endfunction

  // Model advances on each rising edge from the inputs held over the cycle.
  always @(posedge clk) begin
    bit do_pop, do_push;
    int w, off;
    if (rst) begin
      q.delete();
      m_ovf = 0;
      m_cyc = 0;
    end else begin
      m_cyc   = m_cyc + 1;
      do_pop  = (q.size() != 0) && tx_ready;
      do_push = 0;
      if (memwrite) begin
        if (!addr_is_mmio(memaddr)) begin
          w = word_of(memaddr);
          for (int i = 0; i < 4; i++) begin
            if (iobytes[i]) begin
              m_ram[w][8*i +: 8] = memin[8*i +: 8];
              m_known[w][i] = 1'b1;
            end
          end
        end else begin
          off = int'((memaddr - 32'h4000_0000) / 4);
          if (off == 0 && iobytes[0]) begin
            if (q.size() < DEPTH || do_pop) do_push = 1;
            else m_ovf = 1;
          end else if (off == 1) begin
            m_ovf = 0;
          end
        end
      end
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(memin[7:0]);
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic [31:0] msk;
    if (started) begin
      msk = model_mask(memaddr);
      chk("memout", memout & msk, model_read(memaddr) & msk);
      chk("tx_valid", {31'b0, tx_valid}, {31'b0, q.size() != 0});
      chk("tx_data", {24'b0, tx_data}, {24'b0, (q.size() != 0) ? q[0] : 8'h00});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    memaddr  = a;
    memin    = d;
    iobytes  = be;
    memwrite = 1'b1;
    step();
    memwrite = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    memaddr = a;
    #1;
    chk(name, memout, exp);
  endtask

  initial begin
    for (int i = 0; i < W; i++) begin
      m_known[i] = 4'h0;
      m_ram[i]   = 32'h0;
    end
    m_ovf = 0;
    m_cyc = 0;
    rst = 1'b1; memaddr = 32'h0; memin = 32'h0; memwrite = 1'b0;
    iobytes = 4'h0; tx_ready = 1'b0;
    step();
    started = 1;
    step();

    // Reset state
    rd_chk("reset_status", 32'h4000_0004, 32'h0000_0001);
    chk("reset_tx_valid", {31'b0, tx_valid}, 32'h0);

    // Cycle counter 10 cycles after reset release
    rst = 1'b0;
    memaddr = 32'h4000_0008;
    repeat (10) step();
`ifdef DMEM_CYCLE_COUNTER_EN
    rd_chk("cycle_10", 32'h4000_0008, 32'd10);
`else
    rd_chk("cycle_off", 32'h4000_0008, 32'd0);
`endif

    // Byte-lane writes
    wr(32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
    wr(32'h0000_0010, 32'h0000_5500, 4'b0010);
    rd_chk("byte_lane", 32'h0000_0010, 32'hDEAD_55EF);
    wr(32'h0000_0014, 32'hFFFF_FFFF, 4'h0);

    // Address wrap to the last word
    wr(32'hFFFF_FFFC, 32'h1122_3344, 4'hF);
    rd_chk("wrap_last", (W - 1) * 4, 32'h1122_3344);
    rd_chk("txdata_reads0", 32'h4000_0000, 32'h0);
    rd_chk("rsvd_reads0", 32'h4000_000C, 32'h0);

    // Overflow with sink stalled
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) wr(32'h4000_0000, 32'h41 + i, 4'h1);
    rd_chk("status_full_ovf", 32'h4000_0004, 32'h0000_0086);
    chk("head_0x41", {24'b0, tx_data}, 32'h41);
    wr(32'h4000_0004, 32'h0, 4'h0);
    rd_chk("status_ovf_clr", 32'h4000_0004, 32'h0000_0082);

    // Push and pop together while full
    tx_ready = 1'b1;
    wr(32'h4000_0000, 32'h5A, 4'h1);
    tx_ready = 1'b0;
    rd_chk("status_full_pp", 32'h4000_0004, 32'h0000_0082);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain", {24'b0, tx_data}, (i == 7) ? 32'h5A : 32'h42 + i);
      step();
    end
    tx_ready = 1'b0;
    chk("drained_valid", {31'b0, tx_valid}, 32'h0);

    // Mid-stream reset discards queued bytes, keeps RAM
    for (int i = 0; i < 3; i++) wr(32'h4000_0000, 32'h61 + i, 4'h1);
    chk("pre_rst_valid", {31'b0, tx_valid}, 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_valid", {31'b0, tx_valid}, 32'h0);
    chk("rst_txdata", {24'b0, tx_data}, 32'h0);
    rd_chk("rst_status", 32'h4000_0004, 32'h0000_0001);
    rd_chk("rst_ram_kept", 32'h0000_0010, 32'hDEAD_55EF);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      case ($urandom_range(0, 3))
        0, 1: memaddr = 32'h4000_0000 | ($urandom_range(0, 15));
        2:    memaddr = $urandom_range(0, 4 * W - 1);
        default: memaddr = $urandom;
      endcase
      memin    = $urandom;
      memwrite = ($urandom_range(0, 2) != 0);
      iobytes  = 4'($urandom_range(0, 15));
      tx_ready = ($urandom_range(0, 3) == 0);
      rst      = ($urandom_range(0, 99) == 0);
      step();
    end
    memwrite = 1'b0;
    rst = 1'b0;
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
